// File: rtl/sw_debounce.sv
// Two-channel switch debouncer: 2-flop synchronizer plus a four-state acceptance FSM per
// channel, registered level/edge outputs and a press counter on channel 0.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_0,
  input  logic       sw_1,
  output logic       sw_0_db,
  output logic       sw_1_db,
  output logic       sw_0_rise,
  output logic       sw_0_fall,
  output logic       sw_1_rise,
  output logic       sw_1_fall,
  output logic [3:0] press_count_0,
  output logic [1:0] state_0,
  output logic [1:0] state_1
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  logic [1:0] raw;
  logic [1:0] db;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] st [2];
  logic       accept_rise_0;

  assign raw = {sw_1, sw_0};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic [1:0]    sync;
    logic          s;
    logic [CW-1:0] cnt;
    state_t        fsm;
    logic          db_r;
    logic          rise_r;
    logic          fall_r;

    assign s = sync[1];

    // The counter starts at 1 because the edge leaving STABLE already saw one sample of
    // the new level; acceptance happens on the DEBOUNCE_CYCLES-th consecutive sample.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync   <= 2'b00;
        cnt    <= '0;
        fsm    <= STABLE_LO;
        db_r   <= 1'b0;
        rise_r <= 1'b0;
        fall_r <= 1'b0;
      end else begin
        sync   <= {sync[0], raw[g]};
        rise_r <= 1'b0;
        fall_r <= 1'b0;
        case (fsm)
          STABLE_LO: begin
            if (s) begin
              fsm <= WAIT_HI;
              cnt <= ONE;
            end
          end
          WAIT_HI: begin
            if (!s) begin
              fsm <= STABLE_LO;
              cnt <= '0;
            end else if (cnt == LAST) begin
              fsm    <= STABLE_HI;
              cnt    <= '0;
              db_r   <= 1'b1;
              rise_r <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          STABLE_HI: begin
            if (!s) begin
              fsm <= WAIT_LO;
              cnt <= ONE;
            end
          end
          WAIT_LO: begin
            if (s) begin
              fsm <= STABLE_HI;
              cnt <= '0;
            end else if (cnt == LAST) begin
              fsm    <= STABLE_LO;
              cnt    <= '0;
              db_r   <= 1'b0;
              fall_r <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: begin
            fsm <= STABLE_LO;
            cnt <= '0;
          end
        endcase
      end
    end

    assign db[g]   = db_r;
    assign rise[g] = rise_r;
    assign fall[g] = fall_r;
    assign st[g]   = fsm;
  end

  // Same condition that sets sw_0_rise, so the count updates on the edge the pulse rises.
  assign accept_rise_0 = (g_chan[0].fsm == WAIT_HI) && g_chan[0].s && (g_chan[0].cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_count_0 <= 4'd0;
    end else if (accept_rise_0) begin
      press_count_0 <= press_count_0 + 4'd1;
    end
  end

  assign sw_0_db   = db[0];
  assign sw_1_db   = db[1];
  assign sw_0_rise = rise[0];
  assign sw_0_fall = fall[0];
  assign sw_1_rise = rise[1];
  assign sw_1_fall = fall[1];
  assign state_0   = st[0];
  assign state_1   = st[1];

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with DEBOUNCE_CYCLES=4: level vectors from a table plus hand-built
// bounce/reset/wrap sequences; expected pulse events are queued and matched per cycle.
module tb_sw_debounce;

  localparam int DC  = 4;
  localparam int LAT = 2 + DC;
  localparam int EW  = 22;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_0;
  logic       sw_1;
  logic       sw_0_db;
  logic       sw_1_db;
  logic       sw_0_rise;
  logic       sw_0_fall;
  logic       sw_1_rise;
  logic       sw_1_fall;
  logic [3:0] press_count_0;
  logic [1:0] state_0;
  logic [1:0] state_1;

  sw_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .sw_0(sw_0), .sw_1(sw_1),
    .sw_0_db(sw_0_db), .sw_1_db(sw_1_db),
    .sw_0_rise(sw_0_rise), .sw_0_fall(sw_0_fall),
    .sw_1_rise(sw_1_rise), .sw_1_fall(sw_1_fall),
    .press_count_0(press_count_0), .state_0(state_0), .state_1(state_1)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic          acc0, acc1;
  logic [3:0]    tally;

  typedef struct {
    logic sw0;
    logic sw1;
    int   cycles;
    logic db0;
    logic db1;
  } vec_t;
  vec_t vecs[11];

  // event = {cycle[15:0], channel, is_fall, press_count}
  function automatic logic [EW-1:0] pack_ev(int c, logic ch, logic is_fall, logic [3:0] cnt);
    logic [15:0] c16;
    c16 = 16'(c);
    return {c16, ch, is_fall, cnt};
  endfunction

  task automatic check1(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(logic ch, logic is_fall);
    if (!ch && !is_fall) tally = tally + 4'd1;
    exp_q.push_back(pack_ev(cyc + LAT, ch, is_fall, tally));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A level held shorter than DC cycles is a glitch and must be reverted by the next call.
  task automatic drive(logic a, logic b, int n);
    sw_0 = a;
    sw_1 = b;
    if (a !== acc0 && n >= DC) begin
      push_ev(1'b0, !a);
      acc0 = a;
    end
    if (b !== acc1 && n >= DC) begin
      push_ev(1'b1, !b);
      acc1 = b;
    end
    step(n);
  endtask

  task automatic check_all_zero(string tag);
    check1({tag, "_db"},    {30'd0, sw_1_db, sw_0_db}, 32'd0);
    check1({tag, "_pulse"}, {28'd0, sw_1_rise, sw_1_fall, sw_0_rise, sw_0_fall}, 32'd0);
    check1({tag, "_count"}, {28'd0, press_count_0}, 32'd0);
    check1({tag, "_state"}, {28'd0, state_1, state_0}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_all_zero("reset");
    step(3);
    rst   = 1'b0;
    acc0  = 1'b0;
    acc1  = 1'b0;
    tally = 4'd0;
  endtask

  // ---------------- monitor ----------------
  task automatic handle(logic ch, logic is_fall);
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    act = pack_ev(cyc, ch, is_fall, press_count_0);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse actual=%0h (cyc %0d ch %0d fall %0b cnt %0d) required=none",
               act, cyc, ch, is_fall, press_count_0);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        errors++;
        $display("FAIL pulse_event actual cyc=%0d ch=%0d fall=%0b cnt=%0d required cyc=%0d ch=%0d fall=%0b cnt=%0d",
                 act[21:6], act[5], act[4], act[3:0], e[21:6], e[5], e[4], e[3:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      while (exp_q.size() > 0 && exp_q[0][21:6] < 16'(cyc)) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse actual=none required cyc=%0d ch=%0d fall=%0b cnt=%0d (now %0d)",
                 exp_q[0][21:6], exp_q[0][5], exp_q[0][4], exp_q[0][3:0], cyc);
        void'(exp_q.pop_front());
      end
      check1("excl_pulse_0", {31'd0, sw_0_rise & sw_0_fall}, 32'd0);
      check1("excl_pulse_1", {31'd0, sw_1_rise & sw_1_fall}, 32'd0);
      if (sw_0_rise | sw_0_fall) handle(1'b0, sw_0_fall);
      if (sw_1_rise | sw_1_fall) handle(1'b1, sw_1_fall);
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    vecs[0]  = '{1'b1, 1'b0,  8, 1'b1, 1'b0};  // clean step on sw_0
    vecs[1]  = '{1'b0, 1'b0,  8, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1,  3, 1'b0, 1'b0};  // 3-cycle glitch on sw_1
    vecs[3]  = '{1'b0, 1'b0,  8, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 10, 1'b1, 1'b1};  // simultaneous rise
    vecs[5]  = '{1'b0, 1'b0, 10, 1'b0, 1'b0};  // simultaneous fall
    vecs[6]  = '{1'b0, 1'b1, 10, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 10, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0,  2, 1'b1, 1'b1};  // low glitch on sw_1 while high
    vecs[9]  = '{1'b1, 1'b1, 10, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 10, 1'b0, 1'b0};

    rst   = 1'b1;
    sw_0  = 1'b0;
    sw_1  = 1'b0;
    acc0  = 1'b0;
    acc1  = 1'b0;
    tally = 4'd0;
    step(3);
    check_all_zero("por");
    rst = 1'b0;
    step(4);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].sw0, vecs[i].sw1, vecs[i].cycles);
      check1($sformatf("vec%0d_db0", i), {31'd0, sw_0_db}, {31'd0, vecs[i].db0});
      check1($sformatf("vec%0d_db1", i), {31'd0, sw_1_db}, {31'd0, vecs[i].db1});
    end

    // bounce: 2-cycle toggles for 20 cycles, then hold high
    for (int i = 0; i < 10; i++) drive((i % 2) == 0, 1'b0, 2);
    check1("bounce_db0_low", {31'd0, sw_0_db}, 32'd0);
    drive(1'b1, 1'b0, 10);
    check1("bounce_db0_high", {31'd0, sw_0_db}, 32'd1);
    drive(1'b0, 1'b0, 10);

    // reset two cycles into WAIT_HI
    sw_0 = 1'b1;
    step(4);
    check1("mid_state_wait", {30'd0, state_0}, 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst_now");
    step(2);
    check_all_zero("mid_rst_hold");
    rst   = 1'b0;
    acc0  = 1'b0;
    acc1  = 1'b0;
    tally = 4'd0;
    push_ev(1'b0, 1'b0);
    acc0 = 1'b1;
    step(10);
    check1("post_rst_db0", {31'd0, sw_0_db}, 32'd1);
    check1("post_rst_count", {28'd0, press_count_0}, 32'd1);
    drive(1'b0, 1'b0, 10);

    // counter wrap over 17 presses
    do_reset();
    step(2);
    for (int p = 1; p <= 17; p++) begin
      drive(1'b1, 1'b0, 8);
      if (p == 15) check1("wrap_count_15", {28'd0, press_count_0}, 32'd15);
      if (p == 16) check1("wrap_count_16", {28'd0, press_count_0}, 32'd0);
      drive(1'b0, 1'b0, 8);
    end
    check1("wrap_count_17", {28'd0, press_count_0}, 32'd1);

    step(10);
    check1("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
